fx_gain_shaper: RTL and testbench
=================================

# fx_gain_shaper

Parametrised successor to the fixed effects pipeline: a fully pipelined per-sample gain → saturate → waveshaper → output-volume chain for the guitar path, with an explicit valid handshake and selectable distortion mode. It sits between the ADC deserialiser and the DAC serialiser. Each sample is processed with the settings captured alongside it, and the block keeps a saturating clip counter for the UI.

## Interface
Parameters:
- SLEN, 16, sample width (signed two's complement)
- GLEN, 10, gain word width (unsigned)
- GFRAC, 3, fractional bits of gain (gain = gain_value / 2^GFRAC)
- CNTW, 16, clip counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_in  in  1  sample_in and all settings are valid this cycle
- sample_in  in  SLEN  signed input sample
- gain_value  in  GLEN  unsigned gain, Q(GLEN-GFRAC).GFRAC
- mode  in  2  00 bypass, 01 gain only, 10 hard clip, 11 soft clip
- threshold  in  SLEN-1  unsigned clip threshold T (positive magnitude)
- volume  in  8  unsigned output volume, Q1.7 (128 = unity)
- clear_stats  in  1  clears clip_count
- valid_out  out  1  sample_out is new this cycle
- sample_out  out  SLEN  signed processed sample
- clip_flag  out  1  the current output sample was saturated or clipped at any stage
- clip_count  out  CNTW  number of valid outputs with clip_flag set; saturates at all-ones

## Operation
- Four register stages; a valid bit travels with each sample. Settings are captured in stage 1 only when valid_in=1, and travel with that sample. Changing settings mid-stream therefore never affects in-flight samples.
- S1: register the sample. Compute the full-width signed product sample_in × gain_value (SLEN+GLEN+1 bits).
- S2: shift right arithmetically by GFRAC (floor). Saturate to [−2^(SLEN−1), 2^(SLEN−1)−1] → g. Set the sat bit if saturation occurred.
- S3, shaping. Magnitude uses |g|, with −2^(SLEN−1) treated as 2^(SLEN−1)−1.
  - 00: y = original sample_in. Gain, volume and flags are ignored; clip_flag = 0.
  - 01: y = g.
  - 10: y = sign(g)·min(|g|, T). Set the clip bit if |g| > T.
  - 11: let H = T>>1. If |g| ≤ H, y = g. Otherwise y = sign(g)·min(H + ((|g|−H)>>1), T). Set the clip bit if |g| > H.
- S4: v = (y × volume) >>> 7 (floor), saturated to SLEN; the sat bit is ORed into the flags. In mode 00, v = y.
- clip_flag = OR of all stage flags for that sample.
- clip_count increments by 1 on each valid_out with clip_flag=1, and holds at 2^CNTW−1.
- clear_stats=1 zeroes clip_count next cycle. If clear_stats=1 and an increment occur in the same cycle, the clear wins (result 0).
- T = 0 in modes 10/11 yields y = 0 for every sample.

## Timing
- Latency: exactly 4 cycles from valid_in=1 at edge k to valid_out=1 at edge k+4.
- Throughput: one sample per cycle. Arbitrary bubbles are allowed; the valid pattern is reproduced delayed by 4 cycles.
- valid_out is a 1-cycle pulse per sample.
- sample_out and clip_flag load only when a valid sample leaves S4. Otherwise they hold their last value.
- Reset, synchronous: all valid bits, sample_out, clip_flag and clip_count go to 0 at the first clk edge with rst=1.
- Reset mid-operation discards all in-flight samples; no valid_out occurs for them.
- While rst=1, valid_in is ignored. The first accepted sample is one with valid_in=1 on the cycle after rst falls.
- No back-pressure: the downstream consumer must accept every valid_out.

## Test plan
- Gain-only path: mode 01, gain_value 80 (×10), sample 12 → sample_out 120, valid_out exactly 4 cycles later, clip_flag 0. Then samples −10, −29, −86 → −100, −290, −860.
- Saturation: mode 01, gain 80, sample 5000 → 32767 with clip_flag 1. Sample −5000 → −32768. clip_count reaches 2.
- Hard clip: mode 10, T=1000, gain 80. Sample 300 → 1000; −300 → −1000; 50 → 500 (clip_flag 0).
- Soft clip and volume: mode 11, T=1000, gain 8 (×1). Input 700 → 600; 3000 → 1000; 400 → 400. With volume 64, input 700 → 300.
- Bypass and setting capture: mode 00, sample −10 → −10 regardless of gain. Switch mode to 01 on the cycle after the bypass sample; that sample still emerges as −10.
- Bubbles, reset and counter: a random valid pattern of 20 samples shows the same pattern at output shifted by 4. Assert rst while 3 samples are in flight → none emerge, and all outputs read 0. Saturate with CNTW=2 → counter holds at 3. A simultaneous clear and increment → 0.

Source files
------------

// File: rtl/fx_gain_shaper.sv
`default_nettype none
// ============================================================================
// Module   : fx_gain_shaper
// Purpose  : 4-stage gain -> saturate -> waveshape -> volume chain with clip stats
// Revision : 1.0
// ============================================================================
module fx_gain_shaper #(
    parameter int SLEN  = 16,
    parameter int GLEN  = 10,
    parameter int GFRAC = 3,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic signed [SLEN-1:0] sample_in,
    input  logic [GLEN-1:0]        gain_value,
    input  logic [1:0]             mode,
    input  logic [SLEN-2:0]        threshold,
    input  logic [7:0]             volume,
    input  logic                   clear_stats,
    output logic                   valid_out,
    output logic signed [SLEN-1:0] sample_out,
    output logic                   clip_flag,
    output logic [CNTW-1:0]        clip_count
);

    localparam int PW = SLEN + GLEN + 1;
    localparam int VW = SLEN + 9;
    localparam logic [1:0] c_MODE_BYP  = 2'b00;
    localparam logic [1:0] c_MODE_GAIN = 2'b01;
    localparam logic [1:0] c_MODE_HARD = 2'b10;
    localparam logic signed [SLEN-1:0] c_MAX = {1'b0, {(SLEN-1){1'b1}}};
    localparam logic signed [SLEN-1:0] c_MIN = {1'b1, {(SLEN-1){1'b0}}};

    // Stage 1: settings are captured only with a valid sample and ride along with it
    logic                   r1_valid;
    logic signed [SLEN-1:0] r1_sample;
    logic signed [PW-1:0]   r1_prod;
    logic [1:0]             r1_mode;
    logic [SLEN-2:0]        r1_thr;
    logic [7:0]             r1_vol;
    logic signed [PW-1:0]   w_prod;

    assign w_prod = sample_in * $signed({1'b0, gain_value});

    always_ff @(posedge clk) begin
        if (rst) r1_valid <= 1'b0;
        else     r1_valid <= valid_in;
        if (valid_in) begin
            r1_sample <= sample_in;
            r1_prod   <= w_prod;
            r1_mode   <= mode;
            r1_thr    <= threshold;
            r1_vol    <= volume;
        end
    end

    // Stage 2: floor-shift and saturate the gained sample
    logic                   r2_valid, r2_sat;
    logic signed [SLEN-1:0] r2_g, r2_sample;
    logic [1:0]             r2_mode;
    logic [SLEN-2:0]        r2_thr;
    logic [7:0]             r2_vol;
    logic signed [PW-1:0]   w_shift;
    logic signed [SLEN-1:0] w_g2;
    logic                   w_sat2;

    assign w_shift = r1_prod >>> GFRAC;

    always_comb begin
        w_g2   = w_shift[SLEN-1:0];
        w_sat2 = 1'b0;
        if (!w_shift[PW-1] && (|w_shift[PW-2:SLEN-1])) begin
            w_g2   = c_MAX;
            w_sat2 = 1'b1;
        end else if (w_shift[PW-1] && !(&w_shift[PW-2:SLEN-1])) begin
            w_g2   = c_MIN;
            w_sat2 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r2_valid <= 1'b0;
        else     r2_valid <= r1_valid;
        r2_g      <= w_g2;
        r2_sat    <= w_sat2;
        r2_sample <= r1_sample;
        r2_mode   <= r1_mode;
        r2_thr    <= r1_thr;
        r2_vol    <= r1_vol;
    end

    // Stage 3: waveshaping on the magnitude; the most negative value folds to max
    logic                   r3_valid, r3_flag;
    logic signed [SLEN-1:0] r3_y;
    logic [1:0]             r3_mode;
    logic [7:0]             r3_vol;
    logic                   w_neg;
    logic [SLEN-2:0]        w_mag, w_half, w_soft, w_lim;
    logic signed [SLEN-1:0] w_y3;
    logic                   w_flag3;

    assign w_neg  = r2_g[SLEN-1];
    assign w_mag  = (r2_g == c_MIN) ? {(SLEN-1){1'b1}} :
                    (w_neg ? (~r2_g[SLEN-2:0] + 1'b1) : r2_g[SLEN-2:0]);
    assign w_half = r2_thr >> 1;
    assign w_soft = w_half + ((w_mag - w_half) >> 1);

    always_comb begin
        w_lim   = w_mag;
        w_y3    = r2_g;
        w_flag3 = r2_sat;
        if (r2_mode == c_MODE_BYP) begin
            w_y3    = r2_sample;
            w_flag3 = 1'b0;
        end else if (r2_mode == c_MODE_HARD) begin
            if (w_mag > r2_thr) begin
                w_lim   = r2_thr;
                w_flag3 = 1'b1;
            end
            w_y3 = w_neg ? -$signed({1'b0, w_lim}) : $signed({1'b0, w_lim});
        end else if (r2_mode != c_MODE_GAIN && w_mag > w_half) begin
            w_lim   = (w_soft > r2_thr) ? r2_thr : w_soft;
            w_flag3 = 1'b1;
            w_y3    = w_neg ? -$signed({1'b0, w_lim}) : $signed({1'b0, w_lim});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r3_valid <= 1'b0;
        else     r3_valid <= r2_valid;
        r3_y    <= w_y3;
        r3_flag <= w_flag3;
        r3_mode <= r2_mode;
        r3_vol  <= r2_vol;
    end

    // Stage 4: Q1.7 output volume with saturation, then output and statistics
    logic signed [VW-1:0]   w_vprod, w_vsh;
    logic signed [SLEN-1:0] w_v4;
    logic                   w_flag4;

    assign w_vprod = r3_y * $signed({1'b0, r3_vol});
    assign w_vsh   = w_vprod >>> 7;

    always_comb begin
        w_v4    = w_vsh[SLEN-1:0];
        w_flag4 = r3_flag;
        if (r3_mode == c_MODE_BYP) begin
            w_v4    = r3_y;
            w_flag4 = 1'b0;
        end else if (!w_vsh[VW-1] && (|w_vsh[VW-2:SLEN-1])) begin
            w_v4    = c_MAX;
            w_flag4 = 1'b1;
        end else if (w_vsh[VW-1] && !(&w_vsh[VW-2:SLEN-1])) begin
            w_v4    = c_MIN;
            w_flag4 = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            sample_out <= '0;
            clip_flag  <= 1'b0;
            clip_count <= '0;
        end else begin
            valid_out <= r3_valid;
            if (r3_valid) begin
                sample_out <= w_v4;
                clip_flag  <= w_flag4;
            end
            if (clear_stats)
                clip_count <= '0;
            else if (r3_valid && w_flag4 && (clip_count != {CNTW{1'b1}}))
                clip_count <= clip_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fx_gain_shaper.sv
`default_nettype none
// ============================================================================
// Module   : tb_fx_gain_shaper
// Purpose  : randomized + directed bench against an arithmetic reference model
// Revision : 1.0
// ============================================================================
module tb_fx_gain_shaper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [15:0] sample_in = '0;
    logic [9:0]  gain_value = '0;
    logic [1:0]  mode = '0;
    logic [14:0] threshold = '0;
    logic [7:0]  volume = '0;
    logic        clear_stats = 1'b0;
    logic        valid_out, clip_flag, valid_out2, clip_flag2;
    logic [15:0] sample_out, sample_out2, clip_count;
    logic [1:0]  clip_count2;

    always #5 clk = ~clk;

    fx_gain_shaper dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .sample_in(sample_in),
        .gain_value(gain_value), .mode(mode), .threshold(threshold), .volume(volume),
        .clear_stats(clear_stats), .valid_out(valid_out), .sample_out(sample_out),
        .clip_flag(clip_flag), .clip_count(clip_count)
    );

    fx_gain_shaper #(.CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .sample_in(sample_in),
        .gain_value(gain_value), .mode(mode), .threshold(threshold), .volume(volume),
        .clear_stats(clear_stats), .valid_out(valid_out2), .sample_out(sample_out2),
        .clip_flag(clip_flag2), .clip_count(clip_count2)
    );

    int  n_chk = 0;
    int  n_fail = 0;
    int  n = 0;
    int  t_mode = 1, t_gain = 80, t_thr = 1000, t_vol = 128;
    bit  ev [0:2047];
    int  es [0:2047];
    bit  ef [0:2047];
    int  m_s = 0, m_cnt = 0, m_cnt2 = 0;
    bit  m_f = 1'b0, prev_clr = 1'b0, prev_rst = 1'b1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // Floor division and clamping written straight from the arithmetic rules
    task automatic ref_model(input int s, input int g, input int m, input int t, input int vol,
                             output int v, output bit f);
        longint p, q, y, mag, h, lim, pv, w;
        longint sg;
        f = 1'b0;
        if (m == 0) begin
            v = s;
            return;
        end
        p = longint'(s) * longint'(g);
        q = p / 8;
        if (p < 0 && (p % 8) != 0) q = q - 1;
        if (q > 32767)       begin q = 32767;  f = 1'b1; end
        else if (q < -32768) begin q = -32768; f = 1'b1; end
        mag = (q == -32768) ? 32767 : ((q < 0) ? -q : q);
        sg  = (q < 0) ? -1 : 1;
        h   = t / 2;
        y   = q;
        if (m == 2) begin
            lim = (mag > t) ? t : mag;
            if (mag > t) f = 1'b1;
            y = sg * lim;
        end else if (m == 3 && mag > h) begin
            lim = h + (mag - h) / 2;
            if (lim > t) lim = t;
            f = 1'b1;
            y = sg * lim;
        end
        pv = y * vol;
        w  = pv / 128;
        if (pv < 0 && (pv % 128) != 0) w = w - 1;
        if (w > 32767)       begin w = 32767;  f = 1'b1; end
        else if (w < -32768) begin w = -32768; f = 1'b1; end
        v = int'(w);
    endtask

    task automatic cyc(input bit v, input int s, input bit clr, input bit r);
        int k, k4, ov;
        bit of;
        @(negedge clk);
        n++;
        k = n % 2048;
        if (prev_rst) begin
            m_s = 0; m_f = 1'b0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (ev[k]) begin m_s = es[k]; m_f = ef[k]; end
            if (prev_clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (ev[k] && ef[k]) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        chk("valid_out", valid_out, ev[k]);
        chk("sample_out", $signed(sample_out), m_s);
        chk("clip_flag", clip_flag, m_f);
        chk("clip_count", clip_count, m_cnt);
        chk("valid_out2", valid_out2, ev[k]);
        chk("sample_out2", $signed(sample_out2), m_s);
        chk("clip_count2", clip_count2, m_cnt2);
        ev[k] = 1'b0;
        valid_in    = v;
        sample_in   = s[15:0];
        gain_value  = t_gain[9:0];
        mode        = t_mode[1:0];
        threshold   = t_thr[14:0];
        volume      = t_vol[7:0];
        clear_stats = clr;
        rst         = r;
        prev_clr    = clr;
        prev_rst    = r;
        if (r) begin
            for (int j = 1; j <= 4; j++) ev[(n + j) % 2048] = 1'b0;
        end else begin
            k4 = (n + 4) % 2048;
            ev[k4] = v;
            if (v) begin
                ref_model(s, t_gain, t_mode, t_thr, t_vol, ov, of);
                es[k4] = ov;
                ef[k4] = of;
            end
        end
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cyc(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] r16;
        for (int i = 0; i < 2048; i++) begin ev[i] = 1'b0; es[i] = 0; ef[i] = 1'b0; end
        repeat (2) @(posedge clk);
        cyc(1'b1, 77, 1'b0, 1'b1);
        idle(2);

        t_mode = 1; t_gain = 80; t_thr = 1000; t_vol = 128;
        cyc(1'b1, 12, 1'b0, 1'b0);
        idle(4);
        chk("gain12_lit", $signed(sample_out), 120);
        chk("gain12_flag", clip_flag, 0);
        cyc(1'b1, -10, 1'b0, 1'b0);
        cyc(1'b1, -29, 1'b0, 1'b0);
        cyc(1'b1, -86, 1'b0, 1'b0);
        cyc(1'b1, 5000, 1'b0, 1'b0);
        cyc(1'b1, -5000, 1'b0, 1'b0);
        idle(4);
        chk("neg_sat_lit", $signed(sample_out), -32768);
        chk("sat_count_lit", clip_count, 2);

        t_mode = 2;
        cyc(1'b1, 300, 1'b0, 1'b0);
        cyc(1'b1, -300, 1'b0, 1'b0);
        cyc(1'b1, 50, 1'b0, 1'b0);
        idle(4);
        chk("hard50_lit", $signed(sample_out), 500);

        t_mode = 3; t_gain = 8;
        cyc(1'b1, 700, 1'b0, 1'b0);
        cyc(1'b1, 3000, 1'b0, 1'b0);
        cyc(1'b1, 400, 1'b0, 1'b0);
        t_vol = 64;
        cyc(1'b1, 700, 1'b0, 1'b0);
        idle(4);
        chk("soft_vol_lit", $signed(sample_out), 300);

        t_vol = 128; t_mode = 0; t_gain = 80;
        cyc(1'b1, -10, 1'b0, 1'b0);
        t_mode = 1;
        idle(4);
        chk("bypass_capture_lit", $signed(sample_out), -10);

        repeat (6) cyc(1'b1, 5000, 1'b0, 1'b0);
        idle(4);
        chk("cnt2_hold_lit", clip_count2, 3);

        cyc(1'b1, -5000, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        chk("clr_wins_lit", clip_count, 0);

        for (int i = 0; i < 400; i++) begin
            t_mode = $urandom_range(0, 3);
            t_gain = $urandom_range(0, 1023);
            t_thr  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 32767);
            t_vol  = $urandom_range(0, 255);
            r16    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) r16 = 16'($signed(r16) >>> 8);
            cyc($urandom_range(0, 2) != 0, int'($signed(r16)), $urandom_range(0, 15) == 0, 1'b0);
        end
        idle(4);

        t_mode = 1; t_gain = 80; t_vol = 128;
        cyc(1'b1, 100, 1'b0, 1'b0);
        cyc(1'b1, 5000, 1'b0, 1'b0);
        cyc(1'b1, 300, 1'b0, 1'b0);
        cyc(1'b1, 400, 1'b0, 1'b1);
        cyc(1'b1, 55, 1'b0, 1'b0);
        chk("rst_sample_lit", $signed(sample_out), 0);
        chk("rst_count_lit", clip_count, 0);
        idle(6);
        chk("post_rst_lit", $signed(sample_out), 550);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
